// File: rtl/memory_file.sv
// Word-addressed data memory: DEPTH x 32-bit words, one combinational read port
// and one rising-edge write port, with asynchronous active-low reset to a fixed pattern.
module memory_file #(
    parameter int DEPTH        = 64,
    parameter int ADDR_BITS    = 6,
    parameter int INIT_PATTERN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadSelect1,
    input  logic [31:0] WriteSelect,
    input  logic [31:0] WriteData,
    input  logic        WriteEnable,
    output logic [31:0] ReadData1
);

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] rd_idx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic                 rd_in_range;
    logic                 wr_in_range;
    logic                 wr_fire;

    // Upper select bits must be zero; there is no aliasing onto low words.
    assign rd_idx      = ReadSelect1[ADDR_BITS-1:0];
    assign wr_idx      = WriteSelect[ADDR_BITS-1:0];
    assign rd_in_range = (ReadSelect1[31:ADDR_BITS] == '0);
    assign wr_in_range = (WriteSelect[31:ADDR_BITS] == '0);
    assign wr_fire     = WriteEnable && wr_in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (INIT_PATTERN == 1) ? 32'(i) : 32'h0000_0000;
            end
        end else if (wr_fire) begin
            mem_q[wr_idx] <= WriteData;
        end
    end

    // No bypass: a same-address read sees the new word only after the edge.
    assign ReadData1 = rd_in_range ? mem_q[rd_idx] : 32'h0000_0000;

endmodule

// File: tb/tb_memory_file.sv
// Self-checking bench for memory_file: directed scenarios plus random traffic,
// with reads scored against an array-based reference model through an expected queue.
module tb_memory_file;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic [31:0] ReadSelect1;
    logic [31:0] WriteSelect;
    logic [31:0] WriteData;
    logic        WriteEnable;
    logic [31:0] ReadData1;

    memory_file #(
        .DEPTH        (DEPTH),
        .ADDR_BITS    (6),
        .INIT_PATTERN (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ReadSelect1 (ReadSelect1),
        .WriteSelect (WriteSelect),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .ReadData1   (ReadData1)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // reference model and scoreboard
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        sample_req;
    int          n_compared;
    int          n_mismatch;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = i;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < DEPTH) return model[a[5:0]];
        return 32'h0000_0000;
    endfunction

    // monitor: pops the expected value whenever the driver presents a read
    initial begin
        forever begin
            @(sample_req);
            while (exp_q.size() > 0) begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_compared++;
                if (ReadData1 !== e) begin
                    n_mismatch++;
                    $display("FAIL %s: got %h expected %h (sel %h)", nm, ReadData1, e, ReadSelect1);
                end
            end
        end
    end

    // driver tasks
    task automatic check_read(input logic [31:0] addr, input string tag);
        ReadSelect1 = addr;
        #1;
        exp_q.push_back(model_read(addr));
        name_q.push_back(tag);
        sample_req = ~sample_req;
        #1;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic en);
        @(negedge clk);
        WriteSelect = addr;
        WriteData   = data;
        WriteEnable = en;
        @(posedge clk);
        if (en && reset && addr < DEPTH) model[addr[5:0]] = data;
        #1;
        WriteEnable = 1'b0;
    endtask

    initial begin
        n_compared  = 0;
        n_mismatch  = 0;
        sample_req  = 1'b0;
        reset       = 1'b1;
        ReadSelect1 = '0;
        WriteSelect = '0;
        WriteData   = '0;
        WriteEnable = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // reset state, visible during and after reset
        #1;
        reset = 1'b0;
        model_reset();
        check_read(32'd3, "in_reset_3");
        #9;
        reset = 1'b1;
        check_read(32'd3,  "init_3");
        check_read(32'd0,  "init_0");
        check_read(32'd63, "init_63");

        // basic write
        drive_write(32'd5, 32'hDEADBEEF, 1'b1);
        check_read(32'd5, "write_5");
        check_read(32'd4, "neighbour_4");

        // disabled write over several edges
        for (int k = 0; k < 4; k++) drive_write(32'd7, 32'h12345678, 1'b0);
        check_read(32'd7, "we0_7");

        // out-of-range writes and reads
        drive_write(32'd64, 32'hAAAA5555, 1'b1);
        check_read(32'd0,  "oor_w_alias_0");
        check_read(32'd64, "oor_r_64");
        drive_write(32'h8000_0001, 32'h5555AAAA, 1'b1);
        check_read(32'd1,           "oor_w_alias_1");
        check_read(32'h8000_0005,   "oor_r_hi");

        // reset mid-operation, blocked write, first write after release
        drive_write(32'd9, 32'hCAFEF00D, 1'b1);
        check_read(32'd9, "pre_reset_9");
        reset = 1'b0;
        model_reset();
        check_read(32'd9, "async_reset_9");
        check_read(32'd5, "async_reset_5");
        drive_write(32'd9, 32'h11112222, 1'b1);
        check_read(32'd9, "write_in_reset_9");
        #1;
        reset = 1'b1;
        drive_write(32'd9, 32'h55AA55AA, 1'b1);
        check_read(32'd9, "first_write_after_release");

        // read-during-write, same address
        @(negedge clk);
        WriteSelect = 32'd10;
        WriteData   = 32'h0BADF00D;
        WriteEnable = 1'b1;
        check_read(32'd10, "rdw_before_edge");
        @(posedge clk);
        model[10] = 32'h0BADF00D;
        #1;
        WriteEnable = 1'b0;
        check_read(32'd10, "rdw_after_edge");

        // random traffic, including reads of other words while a write is pending
        for (int n = 0; n < 300; n++) begin
            logic [31:0] wa;
            logic [31:0] ra;
            logic [31:0] wd;
            logic        we;
            wa = (($urandom_range(0, 9)) == 0) ? $urandom : $urandom_range(0, 79);
            ra = (($urandom_range(0, 9)) == 0) ? $urandom : $urandom_range(0, 79);
            wd = $urandom;
            we = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            WriteSelect = wa;
            WriteData   = wd;
            WriteEnable = we;
            check_read(ra, "rnd_pre_edge");
            @(posedge clk);
            if (we && wa < DEPTH) model[wa[5:0]] = wd;
            #1;
            WriteEnable = 1'b0;
            check_read(ra, "rnd_post_edge");
        end

        // drain the scoreboard with a bounded wait
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) #1;
        if (exp_q.size() > 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
